// File: rtl/nanov_digit_alu.sv
// nanov_digit_alu: digit-serial RV32I execute unit, operands arrive LSB digit first.
// ADD/SUB/logic results stream out one cycle behind their inputs; shifts and SLT/SLTU use a second output phase.
module nanov_digit_alu #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DIGIT = 1,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [DIGIT-1:0] a_in,
    input  logic [DIGIT-1:0] b_in,
    output logic             busy,
    output logic             res_valid,
    output logic [DIGIT-1:0] res_out,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             ltu
);
    localparam int unsigned N  = XLEN / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_IN, S_OUT} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    beat_q, beat_d;
    logic [3:0]       op_q, op_d;
    logic             add_c_q, add_c_d;
    logic             sub_c_q, sub_c_d;
    logic             eq_acc_q, eq_acc_d;
    logic [XLEN-1:0]  buf_q, buf_d;
    logic [SHW-1:0]   shamt_q, shamt_d;
    logic             busy_q, busy_d;
    logic             res_valid_q, res_valid_d;
    logic [DIGIT-1:0] res_q, res_d;
    logic             done_q, done_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             ltu_q, ltu_d;

    logic             accept;
    logic [3:0]       op_cur;
    logic [CW-1:0]    beat_cur;
    logic             late;
    logic             is_sub;
    logic             last_in;
    logic [DIGIT:0]   add_sum;
    logic [DIGIT:0]   sub_sum;
    logic             eq_run;
    logic [DIGIT-1:0] stream_dig;
    logic [XLEN-1:0]  shifted;

    // Beat 0 is processed in the accept cycle itself, before op is latched.
    assign accept   = (state_q == S_IDLE) && !busy_q && start;
    assign op_cur   = accept ? op : op_q;
    assign beat_cur = accept ? '0 : beat_q;
    assign late     = (op_cur[2:0] == 3'd1) || (op_cur[2:0] == 3'd2) ||
                      (op_cur[2:0] == 3'd3) || (op_cur[2:0] == 3'd5);
    assign is_sub   = (op_cur[2:0] == 3'd0) && op_cur[3];
    assign last_in  = (state_q == S_IN) && (beat_q == CW'(N - 1));

    // The subtractor always runs: it feeds SUB results and the comparison flags.
    assign add_sum = ({1'b0, a_in} + {1'b0, b_in}) + (DIGIT + 1)'(accept ? 1'b0 : add_c_q);
    assign sub_sum = ({1'b0, a_in} + {1'b0, ~b_in}) + (DIGIT + 1)'(accept ? 1'b1 : sub_c_q);
    assign eq_run  = (accept ? 1'b1 : eq_acc_q) && (sub_sum[DIGIT-1:0] == '0);

    always_comb begin
        case (op_cur[2:0])
            3'd0:    stream_dig = is_sub ? sub_sum[DIGIT-1:0] : add_sum[DIGIT-1:0];
            3'd4:    stream_dig = a_in ^ b_in;
            3'd6:    stream_dig = a_in | b_in;
            3'd7:    stream_dig = a_in & b_in;
            default: stream_dig = '0;
        endcase
    end

    always_comb begin
        if (op_q[2:0] == 3'd1) begin
            shifted = buf_q << shamt_q;
        end else if (op_q[3]) begin
            shifted = $unsigned($signed(buf_q) >>> shamt_q);
        end else begin
            shifted = buf_q >> shamt_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        op_d        = op_q;
        add_c_d     = add_c_q;
        sub_c_d     = sub_c_q;
        eq_acc_d    = eq_acc_q;
        buf_d       = buf_q;
        shamt_d     = shamt_q;
        busy_d      = 1'b0;
        res_valid_d = 1'b0;
        res_d       = '0;
        done_d      = 1'b0;
        eq_d        = eq_q;
        lt_d        = lt_q;
        ltu_d       = ltu_q;

        if (accept || (state_q == S_IN)) begin
            busy_d   = 1'b1;
            beat_d   = beat_cur + CW'(1);
            add_c_d  = add_sum[DIGIT];
            sub_c_d  = sub_sum[DIGIT];
            eq_acc_d = eq_run;
            buf_d[int'(beat_cur) * int'(DIGIT) +: DIGIT] = a_in;
            for (int i = 0; i < int'(SHW); i++) begin
                if (int'(beat_cur) == i / int'(DIGIT)) begin
                    shamt_d[i] = b_in[i % int'(DIGIT)];
                end
            end
            if (accept) begin
                op_d    = op;
                state_d = S_IN;
            end
            if (!late) begin
                res_valid_d = 1'b1;
                res_d       = stream_dig;
            end
            // Top digit: resolve the flags from the final borrow and sign bits.
            if (last_in) begin
                beat_d = '0;
                eq_d   = eq_run;
                ltu_d  = ~sub_sum[DIGIT];
                lt_d   = (a_in[DIGIT-1] != b_in[DIGIT-1]) ? a_in[DIGIT-1] : sub_sum[DIGIT-1];
                if (late) begin
                    state_d = S_OUT;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        end else if (state_q == S_OUT) begin
            busy_d      = 1'b1;
            res_valid_d = 1'b1;
            beat_d      = beat_q + CW'(1);
            if (op_q[2:1] == 2'b01) begin
                res_d = (beat_q == '0) ? DIGIT'(op_q[0] ? ltu_q : lt_q) : '0;
            end else begin
                res_d = shifted[int'(beat_q) * int'(DIGIT) +: DIGIT];
            end
            if (beat_q == CW'(N - 1)) begin
                beat_d  = '0;
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            op_q        <= '0;
            add_c_q     <= 1'b0;
            sub_c_q     <= 1'b0;
            eq_acc_q    <= 1'b0;
            buf_q       <= '0;
            shamt_q     <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
            done_q      <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
            ltu_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            op_q        <= op_d;
            add_c_q     <= add_c_d;
            sub_c_q     <= sub_c_d;
            eq_acc_q    <= eq_acc_d;
            buf_q       <= buf_d;
            shamt_q     <= shamt_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_q       <= res_d;
            done_q      <= done_d;
            eq_q        <= eq_d;
            lt_q        <= lt_d;
            ltu_q       <= ltu_d;
        end
    end

    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_out   = res_q;
    assign done      = done_q;
    assign eq        = eq_q;
    assign lt        = lt_q;
    assign ltu       = ltu_q;

endmodule

// File: tb/tb_nanov_digit_alu.sv
// Bench for nanov_digit_alu: one instance per DIGIT width (1, 2, 4, 8) behind a shared driver;
// a queue of hand-computed expectations is drained by an independent output monitor.
`timescale 1ns/1ps
module tb_nanov_digit_alu;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        eq;
        logic        lt;
        logic        ltu;
        int          t0;
        int          lat_done;
        int          lat_first;
        int          ndig;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start_d;
    logic [3:0] op;
    logic [7:0] a_dig;
    logic [7:0] b_dig;
    logic [1:0] sel;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];

    logic [3:0] st_w, busy_w, val_w, done_w, eq_w, lt_w, ltu_w;
    logic [0:0] r1;
    logic [1:0] r2;
    logic [3:0] r4;
    logic [7:0] r8;
    logic       m_busy, m_valid, m_done, m_eq, m_lt, m_ltu;
    logic [7:0] m_res;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign st_w[0] = start_d && (sel == 2'd0);
    assign st_w[1] = start_d && (sel == 2'd1);
    assign st_w[2] = start_d && (sel == 2'd2);
    assign st_w[3] = start_d && (sel == 2'd3);

    nanov_digit_alu #(.XLEN(32), .DIGIT(1), .SHW(5)) u_d1 (
        .clk(clk), .rstn(rstn), .start(st_w[0]), .op(op), .a_in(a_dig[0:0]), .b_in(b_dig[0:0]),
        .busy(busy_w[0]), .res_valid(val_w[0]), .res_out(r1), .done(done_w[0]),
        .eq(eq_w[0]), .lt(lt_w[0]), .ltu(ltu_w[0]));
    nanov_digit_alu #(.XLEN(32), .DIGIT(2), .SHW(5)) u_d2 (
        .clk(clk), .rstn(rstn), .start(st_w[1]), .op(op), .a_in(a_dig[1:0]), .b_in(b_dig[1:0]),
        .busy(busy_w[1]), .res_valid(val_w[1]), .res_out(r2), .done(done_w[1]),
        .eq(eq_w[1]), .lt(lt_w[1]), .ltu(ltu_w[1]));
    nanov_digit_alu #(.XLEN(32), .DIGIT(4), .SHW(5)) u_d4 (
        .clk(clk), .rstn(rstn), .start(st_w[2]), .op(op), .a_in(a_dig[3:0]), .b_in(b_dig[3:0]),
        .busy(busy_w[2]), .res_valid(val_w[2]), .res_out(r4), .done(done_w[2]),
        .eq(eq_w[2]), .lt(lt_w[2]), .ltu(ltu_w[2]));
    nanov_digit_alu #(.XLEN(32), .DIGIT(8), .SHW(5)) u_d8 (
        .clk(clk), .rstn(rstn), .start(st_w[3]), .op(op), .a_in(a_dig[7:0]), .b_in(b_dig[7:0]),
        .busy(busy_w[3]), .res_valid(val_w[3]), .res_out(r8), .done(done_w[3]),
        .eq(eq_w[3]), .lt(lt_w[3]), .ltu(ltu_w[3]));

    // View of whichever instance is currently selected.
    always_comb begin
        m_busy  = busy_w[sel];
        m_valid = val_w[sel];
        m_done  = done_w[sel];
        m_eq    = eq_w[sel];
        m_lt    = lt_w[sel];
        m_ltu   = ltu_w[sel];
        case (sel)
            2'd0:    m_res = 8'(r1);
            2'd1:    m_res = 8'(r2);
            2'd2:    m_res = 8'(r4);
            default: m_res = r8;
        endcase
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=0x%08h want=0x%08h", name, got, want);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " busy"},      32'(m_busy),  32'd0);
        check({tag, " res_valid"}, 32'(m_valid), 32'd0);
        check({tag, " res_out"},   32'(m_res),   32'd0);
        check({tag, " done"},      32'(m_done),  32'd0);
        check({tag, " eq"},        32'(m_eq),    32'd0);
        check({tag, " lt"},        32'(m_lt),    32'd0);
        check({tag, " ltu"},       32'(m_ltu),   32'd0);
    endtask

    // Called at a negedge; drives one digit per cycle and leaves at the negedge after the last beat.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] r, input logic e_eq,
                          input logic e_lt, input logic e_ltu, input int poke, input bit push);
        int   dw;
        int   n;
        bit   late;
        exp_t e;
        dw   = 1 << sel;
        n    = 32 / dw;
        late = (o[2:0] == 3'd1) || (o[2:0] == 3'd2) || (o[2:0] == 3'd3) || (o[2:0] == 3'd5);
        e.tag       = tag;
        e.res       = r;
        e.eq        = e_eq;
        e.lt        = e_lt;
        e.ltu       = e_ltu;
        e.t0        = cyc;
        e.lat_done  = late ? 2 * n : n;
        e.lat_first = late ? n + 1 : 1;
        e.ndig      = n;
        if (push) sb.push_back(e);
        for (int k = 0; k < n; k++) begin
            start_d = (k == 0) || (k == poke);
            op      = o;
            a_dig   = 8'((a >> (k * dw)) & ((32'd1 << dw) - 32'd1));
            b_dig   = 8'((b >> (k * dw)) & ((32'd1 << dw) - 32'd1));
            @(negedge clk);
        end
        start_d = 1'b0;
        a_dig   = 8'd0;
        b_dig   = 8'd0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (m_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, " idle"}, 32'(m_busy), 32'd0);
    endtask

    initial begin : monitor
        logic [31:0] acc;
        int          pos;
        int          ndig;
        int          first_cyc;
        bit          bad_zero;
        exp_t        e;
        acc = '0; pos = 0; ndig = 0; first_cyc = -1; bad_zero = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                acc = '0; pos = 0; ndig = 0; first_cyc = -1; bad_zero = 1'b0;
            end else begin
                if (m_valid) begin
                    if (ndig == 0) first_cyc = cyc;
                    acc = acc | (32'(m_res) << pos);
                    pos += (1 << sel);
                    ndig++;
                end else if (m_res != 8'd0) begin
                    bad_zero = 1'b1;
                end
                if (m_done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done got done=1 want no pending operation");
                    end else begin
                        e = sb.pop_front();
                        check({e.tag, " result"},      acc,                      e.res);
                        check({e.tag, " eq"},          32'(m_eq),                32'(e.eq));
                        check({e.tag, " lt"},          32'(m_lt),                32'(e.lt));
                        check({e.tag, " ltu"},         32'(m_ltu),               32'(e.ltu));
                        check({e.tag, " done_lat"},    32'(cyc - e.t0),          32'(e.lat_done));
                        check({e.tag, " first_lat"},   32'(first_cyc - e.t0),    32'(e.lat_first));
                        check({e.tag, " digits"},      32'(ndig),                32'(e.ndig));
                        check({e.tag, " idle_res0"},   32'(bad_zero),            32'd0);
                    end
                    acc = '0; pos = 0; ndig = 0; first_cyc = -1; bad_zero = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        rstn = 1'b0; start_d = 1'b0; op = 4'd0; a_dig = 8'd0; b_dig = 8'd0; sel = 2'd0;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            check_zero($sformatf("reset_d%0d", 1 << s));
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // DIGIT=4
        sel = 2'd2;
        run_op("add4",   4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b0, -1, 1'b1);
        wait_idle("add4");
        run_op("sub4",   4'h8, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b1, 5, 1'b1);
        wait_idle("sub4");
        run_op("slt4",   4'h2, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b0, -1, 1'b1);
        wait_idle("slt4");
        run_op("sltu4",  4'h3, 32'h00000005, 32'h00000007, 32'h00000001, 1'b0, 1'b1, 1'b1, -1, 1'b1);
        wait_idle("sltu4");
        run_op("sltu4eq",4'h3, 32'h00001234, 32'h00001234, 32'h00000000, 1'b1, 1'b0, 1'b0, -1, 1'b1);
        wait_idle("sltu4eq");
        run_op("and4",   4'h7, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b1, 1'b0, -1, 1'b1);
        wait_idle("and4");
        run_op("or4",    4'h6, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b1, 1'b0, -1, 1'b1);
        wait_idle("or4");

        // DIGIT=2 shifts
        sel = 2'd1;
        run_op("sra2",   4'hD, 32'hF0000000, 32'hFFFFFFE4, 32'hFF000000, 1'b0, 1'b1, 1'b1, -1, 1'b1);
        wait_idle("sra2");
        run_op("srl2",   4'h5, 32'hF0000000, 32'hFFFFFFE4, 32'h0F000000, 1'b0, 1'b1, 1'b1, -1, 1'b1);
        wait_idle("srl2");
        run_op("sll2",   4'h1, 32'hF0000000, 32'hFFFFFFE4, 32'h00000000, 1'b0, 1'b1, 1'b1, -1, 1'b1);
        wait_idle("sll2");
        run_op("sra2_31",4'hD, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, -1, 1'b1);
        wait_idle("sra2_31");
        run_op("srl2_31",4'h5, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b1, 1'b0, -1, 1'b1);
        wait_idle("srl2_31");

        // DIGIT=1
        sel = 2'd0;
        run_op("xor1",   4'h4, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b0, -1, 1'b1);
        wait_idle("xor1");
        run_op("xor1b3", 4'hC, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, -1, 1'b1);
        wait_idle("xor1b3");
        run_op("add1wrap",4'h0,32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0, -1, 1'b1);
        wait_idle("add1wrap");
        run_op("sll1",   4'h1, 32'h80000001, 32'hFFFFFFE1, 32'h00000002, 1'b0, 1'b1, 1'b1, -1, 1'b1);
        wait_idle("sll1");
        run_op("slt1b3", 4'hA, 32'h00000007, 32'h00000005, 32'h00000000, 1'b0, 1'b0, 1'b0, -1, 1'b1);
        wait_idle("slt1b3");

        // DIGIT=8: SRA aborted by reset in its output phase
        sel = 2'd3;
        run_op("sra8_abort", 4'hD, 32'h80000000, 32'h00000004, 32'h0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        @(negedge clk);
        check("sra8 busy_before_reset", 32'(m_busy), 32'd1);
        check("sra8 lt_before_reset",   32'(m_lt),   32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_zero("async_reset_d8");
        @(negedge clk);
        #2;
        rstn = 1'b1;
        @(negedge clk);
        run_op("add8",   4'h0, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1'b1, 1'b1, -1, 1'b1);
        wait_idle("add8");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nanov_digit_alu.md
# nanov_digit_alu

Digit-serial RV32I execute unit, parametrised successor of the bit-serial nanoV datapath. Processes operands DIGIT bits per clock, LSB digit first. Owns its own beat counter and start/done handshake. Adds a buffered output phase for shifts and set-less-than, and always-on eq/lt/ltu branch flags.

## Interface
- XLEN, 32: operand width; must be a multiple of DIGIT.
- DIGIT, 1: bits per beat; legal values are 1, 2, 4 and 8. N = XLEN/DIGIT beats.
- SHW, 5: shift-amount width; equals log2(XLEN).
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- start  in  1  begin an operation; accepted only while busy=0. Digit 0 is presented in the same cycle.
- op  in  4  {funct7[5], funct3}: 0 ADD, 8 SUB, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 13 SRA, 6 OR, 7 AND. op[3] is ignored except for funct3 0 and 5.
- a_in  in  DIGIT  operand A digit (rs1).
- b_in  in  DIGIT  operand B digit (rs2 or immediate).
- busy  out  1  operation in progress.
- res_valid  out  1  res_out carries a result digit.
- res_out  out  DIGIT  result digit, LSB digit first; 0 when res_valid=0.
- done  out  1  single-cycle pulse on the final busy cycle.
- eq, lt, ltu  out  1 each  comparison of A against B for the last operation; lt is signed, ltu is unsigned.

## Operation
- States: IDLE, IN, OUT. A start accepted in IDLE latches op, clears the beat counter and eq accumulator, and goes to IN.
- Input beats: beat k is on a_in/b_in in cycle T0+k, for k=0..N-1, where T0 is the start cycle. The caller must not stall.
- Internal subtractor runs on every op: diff = A + ~B + 1, with the borrow registered between digits.
  - eq accumulates over beats: eq = no diff digit was nonzero.
  - ltu = ~carry_out of the final digit.
  - lt = a_msb if a_msb != b_msb, else diff_msb.
- Streaming ops (ADD, SUB, XOR, OR, AND):
  - Result digit k is registered at the end of beat k, with carry chained across digits.
  - SUB uses an initial carry of 1; ADD uses 0.
  - After the last input beat, state returns to IDLE.
- Late ops (SLT, SLTU, SLL, SRL, SRA):
  - During IN: A is captured into an XLEN buffer; the low SHW bits of B are captured into shamt. Upper B bits are ignored for shifts.
  - After the last beat, go to OUT for N beats.
  - SLT/SLTU output digit 0 = {0…, lt} or {0…, ltu}; all other digits are 0.
  - Shifts output digit j = (buffer shifted by shamt)[j*DIGIT +: DIGIT]. SRA fills with A[XLEN-1]; SLL and SRL fill with 0.
- Flags are registered at the end of the last input beat. They hold until the next accepted start, then update again at that op's last input beat.
- start while busy=1 is ignored, including in the done cycle.
- Reset is asynchronous at any time, including mid-operation: state → IDLE and every output → 0 immediately; buffer contents are don't-care.

## Timing
- Reset values: busy=0, res_valid=0, res_out=0, done=0, eq=0, lt=0, ltu=0.
- Streaming ops:
  - res_valid high T0+1 .. T0+N; res_out at T0+1+k = digit k.
  - busy high T0+1 .. T0+N; done at T0+N.
  - Next start is accepted at T0+N+1 at the earliest.
- Late ops:
  - No res_valid during IN.
  - res_valid high T0+N+1 .. T0+2N.
  - busy high T0+1 .. T0+2N; done at T0+2N.
- Flags are valid from T0+N for all ops.
- Counter wrap: the beat counter wraps from N-1 to 0 at the IN→OUT transition.
- DIGIT=XLEN (N=1) is not supported.

## Test plan
- DIGIT=4, ADD, A=0x7FFFFFFF, B=0x00000001:
  - res digits 0,0,0,0,0,0,0,8 (0x80000000) at T0+1..T0+8.
  - done at T0+8; eq=0, lt=0, ltu=0.
- DIGIT=4, SUB (op=8), A=5, B=7:
  - result 0xFFFFFFFE; lt=1, ltu=1, eq=0.
  - start at T0+9 is accepted; start at T0+5 is ignored.
- DIGIT=4, SLT, A=0x80000000, B=1:
  - no res_valid T0..T0+8; output 0x00000001 at T0+9..T0+16.
  - done at T0+16; lt=1, ltu=0.
- DIGIT=2, A=0xF0000000, B=0xFFFFFFE4 (shamt 4):
  - SRA → 0xFF000000; SRL → 0x0F000000; SLL → 0x00000000; each done at T0+32.
- DIGIT=1, XOR, A=B=0x12345678:
  - result 0; eq=1, lt=0, ltu=0; done at T0+32.
- DIGIT=8, SRA started, rstn pulsed low at T0+5:
  - busy, res_valid, res_out and flags are 0 while rstn is low, without waiting for a clock edge.
  - After release, a new ADD 3+4 gives 7 and done at T0'+4.
